heart_chain_model: RTL and testbench

//  Parametrised cardiac conduction model: NUM_NODES nodes in a linear chain
//  (node 0 = SA pacemaker, node NUM_NODES-1 = ventricle). Each node runs a

---
 rtl/heart_chain_model.sv | 207 ++++++++++++++++++++
 tb/tb_heart_chain_model.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/heart_chain_model.sv
// heart_chain_model
//   Cardiac conduction model: NUM_NODES nodes in a linear chain. Node 0 is the
//   SA pacemaker and node NUM_NODES-1 is the ventricle. Each node runs a
//   REST/ACT/ERP state machine. Path i is a programmable delay line that
//   carries a wave from node i to node i+1.
//
//   Optional feature macro: HEART_RETRO_EN
//     defined   - each path also carries waves i+1 -> i on a second,
//                 independent counter that uses the same delay
//     undefined - forward conduction only
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous reset, active high
//   clk_enable  in   global advance enable; when low all state is frozen
//   ce_out      out  clk_enable passed through
//   AP          in   atrial pace; a rising edge stimulates node 0
//   VP          in   ventricular pace; a rising edge stimulates node N-1
//   SArest      in   node-0 rest time; 0 disables spontaneous firing
//   path_delay  in   delay of path i in bits [i*TW +: TW]; 0 acts as 1
//   ectopic_en  in   a rising edge on bit k stimulates node k
//   node_act    out  one-cycle activation pulse per node
//   block_cnt   out  saturating count of blocked conduction waves
//
// Node states
//   ST_REST | excitable; node 0 counts towards SArest
//   ST_ACT  | activation cycle; node_act is high
//   ST_ERP  | refractory for ERP_CYC cycles

module heart_chain_model #(
  parameter int NUM_NODES = 7,
  parameter int TW        = 16,
  parameter int ERP_CYC   = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_enable,
  output logic                        ce_out,
  input  logic                        AP,
  input  logic                        VP,
  input  logic [TW-1:0]               SArest,
  input  logic [(NUM_NODES-1)*TW-1:0] path_delay,
  input  logic [NUM_NODES-1:0]        ectopic_en,
  output logic [NUM_NODES-1:0]        node_act,
  output logic [7:0]                  block_cnt
);

  localparam int NP = NUM_NODES - 1;
  localparam int EW = $clog2(ERP_CYC + 1);
  localparam logic [EW-1:0] ERP_LOAD = EW'(ERP_CYC - 1);

  typedef enum logic [1:0] {ST_REST, ST_ACT, ST_ERP} node_state_t;

  node_state_t          r_state       [NUM_NODES];
  node_state_t          w_state_nxt   [NUM_NODES];
  logic [EW-1:0]        r_erp_cnt     [NUM_NODES];
  logic [EW-1:0]        w_erp_cnt_nxt [NUM_NODES];
  logic [TW-1:0]        r_fwd_cnt     [NP];
  logic [TW-1:0]        w_fwd_nxt     [NP];
  logic [TW-1:0]        w_dly         [NP];
  logic [TW-1:0]        r_rest_tmr;
  logic [TW-1:0]        w_rest_tmr_nxt;
  logic                 r_ap_q;
  logic                 r_vp_q;
  logic [NUM_NODES-1:0] r_ect_q;
  logic [7:0]           r_block_cnt;
  logic [7:0]           w_block_cnt_nxt;
  logic [NUM_NODES-1:0] w_act;
  logic [NUM_NODES-1:0] w_stim;
  logic [NUM_NODES-1:0] w_fwd_in;
  logic [NUM_NODES-1:0] w_retro_in;
  logic [NP-1:0]        w_fwd_arr;
  logic                 w_sa_fire;
  logic [15:0]          w_blk_sum;
  logic [16:0]          w_blk_tot;

  assign ce_out    = clk_enable;
  assign node_act  = clk_enable ? w_act : '0;
  assign block_cnt = r_block_cnt;

  always_comb begin
    for (int k = 0; k < NUM_NODES; k++) w_act[k] = (r_state[k] == ST_ACT);
  end

  // Path delays; a programmed 0 behaves as 1.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      w_dly[i] = path_delay[i*TW +: TW];
      if (w_dly[i] == '0) w_dly[i] = TW'(1);
    end
  end

  // Forward paths: a source activation loads the delay only when the path is
  // idle. The arrival strobe fires on the last count, so the destination
  // activates D+1 cycles after the source.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      w_fwd_arr[i] = (r_fwd_cnt[i] == TW'(1));
      if (r_fwd_cnt[i] != '0) w_fwd_nxt[i] = r_fwd_cnt[i] - TW'(1);
      else if (w_act[i])      w_fwd_nxt[i] = w_dly[i];
      else                    w_fwd_nxt[i] = '0;
    end
  end
  assign w_fwd_in = {w_fwd_arr, 1'b0};

`ifdef HEART_RETRO_EN
  logic [TW-1:0] r_ret_cnt [NP];
  logic [TW-1:0] w_ret_nxt [NP];

  always_comb begin
    w_retro_in = '0;
    for (int i = 0; i < NP; i++) begin
      w_retro_in[i] = (r_ret_cnt[i] == TW'(1));
      if (r_ret_cnt[i] != '0) w_ret_nxt[i] = r_ret_cnt[i] - TW'(1);
      else if (w_act[i+1])    w_ret_nxt[i] = w_dly[i];
      else                    w_ret_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NP; i++) r_ret_cnt[i] <= '0;
    end else if (clk_enable) begin
      for (int i = 0; i < NP; i++) r_ret_cnt[i] <= w_ret_nxt[i];
    end
  end
`else
  assign w_retro_in = '0;
`endif

  // Node-0 rest timer. It is zero on the first REST cycle and saturates at
  // SArest. The fire test uses >= so that lowering SArest below the running
  // count fires at once instead of stalling the pacemaker.
  always_comb begin
    w_rest_tmr_nxt = '0;
    w_sa_fire      = 1'b0;
    if (r_state[0] == ST_REST) begin
      w_sa_fire      = (SArest != '0) && (r_rest_tmr >= SArest);
      w_rest_tmr_nxt = (r_rest_tmr < SArest) ? r_rest_tmr + TW'(1) : r_rest_tmr;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_NODES; k++)
      w_stim[k] = (ectopic_en[k] & ~r_ect_q[k]) | w_fwd_in[k] | w_retro_in[k];
    w_stim[0]           = w_stim[0] | (AP & ~r_ap_q) | w_sa_fire;
    w_stim[NUM_NODES-1] = w_stim[NUM_NODES-1] | (VP & ~r_vp_q);
  end

  always_comb begin
    for (int k = 0; k < NUM_NODES; k++) begin
      w_state_nxt[k]   = r_state[k];
      w_erp_cnt_nxt[k] = r_erp_cnt[k];
      case (r_state[k])
        ST_REST: if (w_stim[k]) w_state_nxt[k] = ST_ACT;
        ST_ACT: begin
          w_state_nxt[k]   = ST_ERP;
          w_erp_cnt_nxt[k] = ERP_LOAD;
        end
        ST_ERP: begin
          if (r_erp_cnt[k] == '0) w_state_nxt[k] = ST_REST;
          else                    w_erp_cnt_nxt[k] = r_erp_cnt[k] - EW'(1);
        end
        default: w_state_nxt[k] = ST_REST;
      endcase
    end
  end

  // Each arrival at a non-resting node is one block; forward and retro
  // arrivals at the same node in the same cycle count separately.
  always_comb begin
    w_blk_sum = '0;
    for (int k = 0; k < NUM_NODES; k++) begin
      w_blk_sum = w_blk_sum + 16'(w_fwd_in[k]   && (r_state[k] != ST_REST));
      w_blk_sum = w_blk_sum + 16'(w_retro_in[k] && (r_state[k] != ST_REST));
    end
    w_blk_tot       = 17'(r_block_cnt) + 17'(w_blk_sum);
    w_block_cnt_nxt = (w_blk_tot > 17'd255) ? 8'd255 : w_blk_tot[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_NODES; k++) begin
        r_state[k]   <= ST_REST;
        r_erp_cnt[k] <= '0;
      end
      for (int i = 0; i < NP; i++) r_fwd_cnt[i] <= '0;
      r_rest_tmr  <= '0;
      r_ap_q      <= 1'b0;
      r_vp_q      <= 1'b0;
      r_ect_q     <= '0;
      r_block_cnt <= '0;
    end else if (clk_enable) begin
      for (int k = 0; k < NUM_NODES; k++) begin
        r_state[k]   <= w_state_nxt[k];
        r_erp_cnt[k] <= w_erp_cnt_nxt[k];
      end
      for (int i = 0; i < NP; i++) r_fwd_cnt[i] <= w_fwd_nxt[i];
      r_rest_tmr  <= w_rest_tmr_nxt;
      r_ap_q      <= AP;
      r_vp_q      <= VP;
      r_ect_q     <= ectopic_en;
      r_block_cnt <= w_block_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_heart_chain_model.sv
module tb_heart_chain_model;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        ce_out;
  logic        AP;
  logic        VP;
  logic [15:0] SArest;
  logic [95:0] path_delay;
  logic [6:0]  ectopic_en;
  logic [6:0]  node_act;
  logic [7:0]  block_cnt;

  heart_chain_model #(.NUM_NODES(7), .TW(16), .ERP_CYC(50)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .ce_out     (ce_out),
    .AP         (AP),
    .VP         (VP),
    .SArest     (SArest),
    .path_delay (path_delay),
    .ectopic_en (ectopic_en),
    .node_act   (node_act),
    .block_cnt  (block_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is the period after the n-th rising edge since reset release.
  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  int npulse = 0;
  always @(posedge clk) if (!reset && node_act != 7'd0) npulse <= npulse + 1;

  int checks = 0;
  int errors = 0;

  // At cycle t: compare outputs, then drive the input levels for what follows.
  typedef struct {
    int         t;
    logic [6:0] ect;
    logic       ap;
    logic       vp;
    logic       ce;
    logic [6:0] act;
    logic [7:0] blk;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl2[$];
  logic ce_now = 1'b1;

  function automatic vec_t mk(int t, logic [6:0] ect, logic ap, logic vp,
                              logic ce, logic [6:0] act, logic [7:0] blk);
    vec_t v;
    v.t = t; v.ect = ect; v.ap = ap; v.vp = vp; v.ce = ce; v.act = act; v.blk = blk;
    return v;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    if (cyc > t) begin
      checks++;
      errors++;
      $display("FAIL schedule cycle %0d already passed (now %0d)", t, cyc);
    end
    while (cyc < t) @(negedge clk);
  endtask

  task automatic step(input vec_t v);
    wait_cyc(v.t);
    check($sformatf("c%0d node_act", v.t), int'(node_act), int'(v.act));
    check($sformatf("c%0d block_cnt", v.t), int'(block_cnt), int'(v.blk));
    check($sformatf("c%0d ce_out", v.t), int'(ce_out), int'(ce_now));
    ectopic_en = v.ect;
    AP         = v.ap;
    VP         = v.vp;
    clk_enable = v.ce;
    ce_now     = v.ce;
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    reset      = 1'b1;
    clk_enable = 1'b1;
    AP         = 1'b0;
    VP         = 1'b0;
    ectopic_en = '0;
    SArest     = 16'd700;
    path_delay = {6{16'd10}};
    path_delay[2*16 +: 16] = 16'd200;

    // Pacing 701 + 752n; chain offsets +11,+22,+223,+234,+245,+256.
    tbl.push_back(mk(1,    7'h00, 0, 0, 1, 7'b0000000, 0));
    tbl.push_back(mk(700,  7'h00, 0, 0, 1, 7'b0000000, 0));
    tbl.push_back(mk(701,  7'h00, 0, 0, 1, 7'b0000001, 0));
    tbl.push_back(mk(712,  7'h00, 0, 0, 1, 7'b0000010, 0));
    tbl.push_back(mk(721,  7'h01, 0, 0, 1, 7'b0000000, 0)); // ectopic in ERP
    tbl.push_back(mk(722,  7'h01, 0, 0, 1, 7'b0000000, 0));
    tbl.push_back(mk(723,  7'h00, 0, 0, 1, 7'b0000100, 0));
    tbl.push_back(mk(924,  7'h00, 0, 0, 1, 7'b0001000, 0));
    tbl.push_back(mk(935,  7'h00, 0, 0, 1, 7'b0010000, 0));
    tbl.push_back(mk(946,  7'h00, 0, 0, 1, 7'b0100000, 0));
    tbl.push_back(mk(957,  7'h00, 0, 0, 1, 7'b1000000, 0));
    tbl.push_back(mk(1452, 7'h00, 0, 0, 1, 7'b0000000, 0));
    tbl.push_back(mk(1453, 7'h00, 0, 0, 1, 7'b0000001, 0));
    tbl.push_back(mk(1753, 7'h01, 0, 0, 1, 7'b0000000, 0)); // PAC at rest
    tbl.push_back(mk(1754, 7'h00, 0, 0, 1, 7'b0000001, 0));
    tbl.push_back(mk(1765, 7'h00, 0, 0, 1, 7'b0000010, 0));
    tbl.push_back(mk(1977, 7'h00, 0, 0, 1, 7'b0001000, 0));
    tbl.push_back(mk(2010, 7'h00, 0, 0, 1, 7'b1000000, 0));
    tbl.push_back(mk(2205, 7'h00, 0, 0, 1, 7'b0000000, 0)); // old schedule slot
    tbl.push_back(mk(2505, 7'h00, 0, 0, 1, 7'b0000000, 0));
    tbl.push_back(mk(2506, 7'h00, 0, 0, 1, 7'b0000001, 0));
    tbl.push_back(mk(2729, 7'h00, 0, 0, 1, 7'b0001000, 0));
    tbl.push_back(mk(2756, 7'h00, 0, 1, 1, 7'b0000000, 0)); // VP 5 before arrival
    tbl.push_back(mk(2757, 7'h00, 0, 0, 1, 7'b1000000, 0));
    tbl.push_back(mk(2761, 7'h00, 0, 0, 1, 7'b0000000, 0));
    tbl.push_back(mk(2762, 7'h00, 0, 0, 1, 7'b0000000, 1));
    tbl.push_back(mk(2900, 7'h40, 0, 0, 1, 7'b0000000, 1)); // PVC at rest
    tbl.push_back(mk(2901, 7'h00, 0, 0, 1, 7'b1000000, 1));
    tbl.push_back(mk(2912, 7'h00, 0, 0, 1, 7'b0000000, 1));
    tbl.push_back(mk(2923, 7'h00, 0, 0, 1, 7'b0000000, 1));
    tbl.push_back(mk(3258, 7'h00, 0, 0, 1, 7'b0000001, 1));
    tbl.push_back(mk(3400, 7'h00, 0, 0, 0, 7'b0000000, 1)); // freeze 100 edges
    tbl.push_back(mk(3450, 7'h00, 0, 0, 0, 7'b0000000, 1));
    tbl.push_back(mk(3500, 7'h00, 0, 0, 1, 7'b0000000, 1));
    tbl.push_back(mk(4010, 7'h00, 0, 0, 1, 7'b0000000, 1));
    tbl.push_back(mk(4110, 7'h00, 0, 0, 1, 7'b0000001, 1));
    tbl.push_back(mk(4132, 7'h00, 0, 0, 1, 7'b0000100, 1));

    // After the mid-run reset: AP at 300 restarts the pacemaker.
    tbl2.push_back(mk(300,  7'h00, 1, 0, 1, 7'b0000000, 0));
    tbl2.push_back(mk(301,  7'h00, 0, 0, 1, 7'b0000001, 0));
    tbl2.push_back(mk(312,  7'h00, 0, 0, 1, 7'b0000010, 0));
    tbl2.push_back(mk(701,  7'h00, 0, 0, 1, 7'b0000000, 0));
    tbl2.push_back(mk(1052, 7'h00, 0, 0, 1, 7'b0000000, 0));
    tbl2.push_back(mk(1053, 7'h00, 0, 0, 1, 7'b0000001, 0));

    repeat (3) @(negedge clk);
    check("in-reset node_act", int'(node_act), 0);
    check("in-reset block_cnt", int'(block_cnt), 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset while the wave is travelling path 2 (node 3 due at 4333).
    wait_cyc(4200);
    reset = 1'b1;
    #1;
    check("reset node_act", int'(node_act), 0);
    check("reset block_cnt", int'(block_cnt), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base  = npulse;
    wait_cyc(300);
    check("no late pulse after reset", npulse - base, 0);

    for (int i = 0; i < tbl2.size(); i++) step(tbl2[i]);

    // Freeze during ACT: output forced low, activation resumes on re-enable.
    clk_enable = 1'b0;
    #1;
    check("frozen ACT node_act", int'(node_act), 0);
    check("frozen ce_out", int'(ce_out), 0);
    repeat (3) @(negedge clk);
    check("frozen ACT later", int'(node_act), 0);
    clk_enable = 1'b1;
    #1;
    check("resumed ACT node_act", int'(node_act), 1);
    @(negedge clk);
    check("after resumed ACT", int'(node_act), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
